uart_alu_framer: RTL and testbench

Next-generation UART-to-ALU command interface, sitting between uart_core (RX/TX FIFOs) and alu in the top level.
- Operands are generalised to N_OPERAND_BYTES bytes.
- Commands arrive as framed packets with a sync byte and an XOR checksum.
- Every frame gets a status response; detected errors are reported on the UART.
- An inter-byte timeout recovers from truncated frames.

---
 rtl/uart_alu_framer_pkg.sv | 31 +++
 rtl/uart_alu_framer_rx_timeout_timer.sv | 42 ++++
 rtl/uart_alu_framer.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_alu_framer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_framer_pkg.sv
// Shared types and constants for the UART-to-ALU command framer.
package uart_alu_framer_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    OPCODE    = 4'd1,
    OP_A      = 4'd2,
    OP_B      = 4'd3,
    CHECK     = 4'd4,
    EXEC      = 4'd5,
    TX_SYNC   = 4'd6,
    TX_STATUS = 4'd7,
    TX_RESULT = 4'd8
  } state_e;

  localparam logic [7:0] ST_OK         = 8'h00;
  localparam logic [7:0] ST_CHK_ERR    = 8'h01;
  localparam logic [7:0] ST_TIMEOUT    = 8'h02;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // States where a request frame is partially received and the inter-byte timer runs.
  function automatic logic is_frame_state(input state_e s);
    logic r;
    case (s)
      OPCODE, OP_A, OP_B, CHECK: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_alu_framer_rx_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles, pulses expired on the last one.
module rx_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count_q;
  logic [NB_TIMEOUT-1:0] count_d;
  logic                  expired_s;

  // Next-count logic; the counter restarts after every clear or expiry.
  always_comb begin
    expired_s = i_enable && !i_clear && (count_q == LAST_COUNT);
    if (i_clear || expired_s) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + NB_TIMEOUT'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = expired_s;

endmodule

// File: rtl/uart_alu_framer.sv
// Framed UART command interface to the ALU: parses SYNC/OPCODE/A/B/CHK
// requests from the RX FIFO and emits a status (plus result) frame on TX.
module uart_alu_framer
  import uart_alu_framer_pkg::*;
#(
  parameter int                  NB_BYTE         = 8,
  parameter int                  N_OPERAND_BYTES = 2,
  parameter int                  NB_OPCODE       = 6,
  parameter logic [NB_BYTE-1:0]  SYNC_BYTE       = NB_BYTE'(SYNC_BYTE_DEF),
  parameter int                  TIMEOUT_CYCLES  = 1000000,
  parameter int                  NB_TIMEOUT      = 20,
  localparam int                 NB_OP           = NB_BYTE * N_OPERAND_BYTES
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_BYTE-1:0]   i_data_to_read,
  input  logic                 i_fifo_rx_empty,
  input  logic                 i_fifo_tx_full,
  input  logic [NB_OP-1:0]     i_alu_result,
  output logic                 o_fifo_rx_read,
  output logic                 o_fifo_tx_write,
  output logic [NB_BYTE-1:0]   o_data_to_write,
  output logic [NB_OPCODE-1:0] o_alu_opcode,
  output logic [NB_OP-1:0]     o_alu_op_A,
  output logic [NB_OP-1:0]     o_alu_op_B,
  output logic                 o_is_valid,
  output logic                 o_error
);

  localparam int                  NB_IDX   = (N_OPERAND_BYTES > 1) ? $clog2(N_OPERAND_BYTES) : 1;
  localparam logic [NB_IDX-1:0]   LAST_IDX = NB_IDX'(N_OPERAND_BYTES - 1);
  localparam logic [NB_BYTE-1:0]  STAT_OK  = NB_BYTE'(ST_OK);
  localparam logic [NB_BYTE-1:0]  STAT_CHK = NB_BYTE'(ST_CHK_ERR);
  localparam logic [NB_BYTE-1:0]  STAT_TO  = NB_BYTE'(ST_TIMEOUT);

  state_e               state_q,  state_d;
  logic [NB_IDX-1:0]    idx_q,    idx_d;
  logic [NB_BYTE-1:0]   chk_q,    chk_d;
  logic [NB_BYTE-1:0]   status_q, status_d;
  logic [NB_OP-1:0]     result_q, result_d;
  logic [NB_OPCODE-1:0] opcode_q, opcode_d;
  logic [NB_OP-1:0]     op_a_q,   op_a_d;
  logic [NB_OP-1:0]     op_b_q,   op_b_d;
  logic                 valid_q,  valid_d;
  logic                 error_q,  error_d;

  logic                 rx_read_s;
  logic                 tx_write_s;
  logic [NB_BYTE-1:0]   tx_data_s;
  logic                 rx_avail_s;
  logic                 in_frame_s;
  logic                 expired_s;

  assign rx_avail_s = !i_fifo_rx_empty;
  assign in_frame_s = is_frame_state(state_q);

  rx_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .NB_TIMEOUT     (NB_TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (!in_frame_s || rx_avail_s),
    .i_enable  (in_frame_s && !rx_avail_s),
    .o_expired (expired_s)
  );

  // Frame FSM next-state, datapath updates and FIFO handshakes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    status_d   = status_q;
    result_d   = result_q;
    opcode_d   = opcode_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    rx_read_s  = 1'b0;
    tx_write_s = 1'b0;
    tx_data_s  = '0;

    case (state_q)
      IDLE: begin
        rx_read_s = rx_avail_s;
        if (rx_avail_s && (i_data_to_read == SYNC_BYTE)) begin
          state_d = OPCODE;
        end else begin
          state_d = IDLE;
        end
      end

      OPCODE: begin
        rx_read_s = rx_avail_s;
        if (rx_avail_s) begin
          opcode_d = i_data_to_read[NB_OPCODE-1:0];
          chk_d    = i_data_to_read;
          idx_d    = '0;
          state_d  = OP_A;
        end else if (expired_s) begin
          status_d = STAT_TO;
          error_d  = 1'b1;
          state_d  = TX_SYNC;
        end else begin
          state_d  = OPCODE;
        end
      end

      OP_A, OP_B: begin
        rx_read_s = rx_avail_s;
        if (rx_avail_s) begin
          chk_d = chk_q ^ i_data_to_read;
          if (state_q == OP_A) begin
            op_a_d[int'(idx_q)*NB_BYTE +: NB_BYTE] = i_data_to_read;
          end else begin
            op_b_d[int'(idx_q)*NB_BYTE +: NB_BYTE] = i_data_to_read;
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == OP_A) ? OP_B : CHECK;
          end else begin
            idx_d   = idx_q + NB_IDX'(1);
          end
        end else if (expired_s) begin
          status_d = STAT_TO;
          error_d  = 1'b1;
          state_d  = TX_SYNC;
        end else begin
          state_d  = state_q;
        end
      end

      CHECK: begin
        rx_read_s = rx_avail_s;
        if (rx_avail_s) begin
          if (i_data_to_read == chk_q) begin
            state_d  = EXEC;
          end else begin
            status_d = STAT_CHK;
            error_d  = 1'b1;
            state_d  = TX_SYNC;
          end
        end else if (expired_s) begin
          status_d = STAT_TO;
          error_d  = 1'b1;
          state_d  = TX_SYNC;
        end else begin
          state_d  = CHECK;
        end
      end

      EXEC: begin
        result_d = i_alu_result;
        valid_d  = 1'b1;
        status_d = STAT_OK;
        state_d  = TX_SYNC;
      end

      TX_SYNC: begin
        tx_data_s  = SYNC_BYTE;
        tx_write_s = !i_fifo_tx_full;
        if (!i_fifo_tx_full) begin
          state_d = TX_STATUS;
        end else begin
          state_d = TX_SYNC;
        end
      end

      TX_STATUS: begin
        tx_data_s  = status_q;
        tx_write_s = !i_fifo_tx_full;
        if (!i_fifo_tx_full) begin
          idx_d   = '0;
          state_d = (status_q == STAT_OK) ? TX_RESULT : IDLE;
        end else begin
          state_d = TX_STATUS;
        end
      end

      TX_RESULT: begin
        tx_data_s  = result_q[int'(idx_q)*NB_BYTE +: NB_BYTE];
        tx_write_s = !i_fifo_tx_full;
        if (!i_fifo_tx_full) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + NB_IDX'(1);
            state_d = TX_RESULT;
          end
        end else begin
          state_d = TX_RESULT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      chk_q    <= '0;
      status_q <= '0;
      result_q <= '0;
      opcode_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      status_q <= status_d;
      result_q <= result_d;
      opcode_q <= opcode_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  // FIFO strobes are suppressed while reset is held so no byte moves mid-abort.
  assign o_fifo_rx_read  = rx_read_s && !i_reset;
  assign o_fifo_tx_write = tx_write_s && !i_reset;
  assign o_data_to_write = tx_data_s;
  assign o_alu_opcode    = opcode_q;
  assign o_alu_op_A      = op_a_q;
  assign o_alu_op_B      = op_b_q;
  assign o_is_valid      = valid_q;
  assign o_error         = error_q;

endmodule

// File: tb/tb_uart_alu_framer.sv
// Scoreboard bench for uart_alu_framer: an RX FIFO model feeds request
// frames, expected TX bytes are queued at issue time and a monitor compares.
module tb_uart_alu_framer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        tx_full;
  logic [15:0] alu_res;
  logic        o_fifo_rx_read;
  logic        o_fifo_tx_write;
  logic [7:0]  o_data_to_write;
  logic [5:0]  o_alu_opcode;
  logic [15:0] o_alu_op_A;
  logic [15:0] o_alu_op_B;
  logic        o_is_valid;
  logic        o_error;

  int n_cmp     = 0;
  int n_fail    = 0;
  int valid_cnt = 0;
  int error_cnt = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_alu_framer #(
    .TIMEOUT_CYCLES (100),
    .NB_TIMEOUT     (20)
  ) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_data_to_read  (rx_data),
    .i_fifo_rx_empty (rx_empty),
    .i_fifo_tx_full  (tx_full),
    .i_alu_result    (alu_res),
    .o_fifo_rx_read  (o_fifo_rx_read),
    .o_fifo_tx_write (o_fifo_tx_write),
    .o_data_to_write (o_data_to_write),
    .o_alu_opcode    (o_alu_opcode),
    .o_alu_op_A      (o_alu_op_A),
    .o_alu_op_B      (o_alu_op_B),
    .o_is_valid      (o_is_valid),
    .o_error         (o_error)
  );

  // Simple ALU model: opcode 0x20 adds, anything else XORs.
  always_comb begin
    if (o_alu_opcode == 6'h20) alu_res = o_alu_op_A + o_alu_op_B;
    else                       alu_res = o_alu_op_A ^ o_alu_op_B;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RX FIFO model: a pop seen on the falling edge is applied just after the rising edge.
  initial begin
    logic rd;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      rd = o_fifo_rx_read;
      @(posedge clk);
      #1;
      if (rd) begin
        check("rx_read_when_empty", {31'd0, (rx_q.size() == 0)}, 32'd0);
        if (rx_q.size() != 0) void'(rx_q.pop_front());
      end
      rx_empty = (rx_q.size() == 0);
      rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end
  end

  // Monitor: counts pulses and checks every TX byte against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (o_is_valid) valid_cnt++;
      if (o_error)    error_cnt++;
      if (o_fifo_tx_write) begin
        check("tx_write_while_full", {31'd0, tx_full}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL tx_unexpected_byte: got 0x%0h expected no byte", o_data_to_write);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {24'd0, o_data_to_write}, {24'd0, e});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push n bytes, most significant byte of f first.
  task automatic send(input logic [63:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) rx_q.push_back(f[i*8 +: 8]);
  endtask

  task automatic expect_tx(input logic [31:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(f[i*8 +: 8]);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check("tx_drain_pending", exp_q.size(), 32'd0);
    tick(5);
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_rx_read"},  {31'd0, o_fifo_rx_read},  32'd0);
    check({tag, "_tx_write"}, {31'd0, o_fifo_tx_write}, 32'd0);
    check({tag, "_tx_data"},  {24'd0, o_data_to_write}, 32'd0);
    check({tag, "_opcode"},   {26'd0, o_alu_opcode},    32'd0);
    check({tag, "_op_A"},     {16'd0, o_alu_op_A},      32'd0);
    check({tag, "_op_B"},     {16'd0, o_alu_op_B},      32'd0);
    check({tag, "_valid"},    {31'd0, o_is_valid},      32'd0);
    check({tag, "_error"},    {31'd0, o_error},         32'd0);
    tick(1);
  endtask

  initial begin
    int k;
    i_reset = 1'b1;
    tx_full = 1'b0;
    tick(3);
    i_reset = 1'b0;
    check_all_zero("reset");

    // ADD 0x1234 + 0x0101
    send(64'hA5_20_34_12_01_01_06, 7);
    expect_tx(32'hA5_00_35_13, 4);
    drain(200);
    check("s1_valid_cnt", valid_cnt, 32'd1);
    check("s1_error_cnt", error_cnt, 32'd0);
    check("s1_op_A", {16'd0, o_alu_op_A}, 32'h1234);
    check("s1_op_B", {16'd0, o_alu_op_B}, 32'h0101);
    check("s1_opcode", {26'd0, o_alu_opcode}, 32'h20);

    // Bad checksum, then a good frame
    send(64'hA5_20_34_12_01_01_07, 7);
    expect_tx(32'h0000_A5_01, 2);
    drain(200);
    check("s2_error_cnt", error_cnt, 32'd1);
    check("s2_valid_cnt", valid_cnt, 32'd1);
    send(64'hA5_20_FF_00_01_00_DE, 7);
    expect_tx(32'hA5_00_00_01, 4);
    drain(200);
    check("s2b_valid_cnt", valid_cnt, 32'd2);
    check("s2b_op_A", {16'd0, o_alu_op_A}, 32'h00FF);

    // Garbage before a frame
    send(64'h00_FF_5A, 3);
    send(64'hA5_20_34_12_01_01_06, 7);
    expect_tx(32'hA5_00_35_13, 4);
    drain(200);
    check("s3_valid_cnt", valid_cnt, 32'd3);
    check("s3_error_cnt", error_cnt, 32'd1);

    // Truncated frame; no response may appear well before the timeout
    send(64'hA5_20_34, 3);
    tick(60);
    check("s4_no_early_error", error_cnt, 32'd1);
    expect_tx(32'h0000_A5_02, 2);
    drain(200);
    check("s4_error_cnt", error_cnt, 32'd2);
    check("s4_valid_cnt", valid_cnt, 32'd3);

    // TX FIFO full during the response; opcode byte 0x60 keeps low 6 bits 0x20
    tx_full = 1'b1;
    send(64'hA5_60_02_01_04_03_64, 7);
    expect_tx(32'hA5_00_06_04, 4);
    tick(50);
    check("s5_held_bytes", exp_q.size(), 32'd4);
    check("s5_valid_cnt", valid_cnt, 32'd4);
    check("s5_opcode", {26'd0, o_alu_opcode}, 32'h20);
    tx_full = 1'b0;
    drain(200);

    // Reset mid-frame, then a fresh frame
    send(64'hA5_20_12, 3);
    k = 0;
    while (rx_q.size() != 0 && k < 50) begin
      tick(1);
      k++;
    end
    check("s6_rx_consumed", rx_q.size(), 32'd0);
    tick(2);
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    check_all_zero("s6_reset");
    send(64'hA5_20_34_12_01_01_06, 7);
    expect_tx(32'hA5_00_35_13, 4);
    drain(200);
    check("s6_valid_cnt", valid_cnt, 32'd5);
    check("s6_error_cnt", error_cnt, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
